// File: rtl/itcm_arbiter.sv
// itcm_arbiter: round-robin IFU/LSU arbiter and one-cycle sequencer for the single-port ITCM RAM
module itcm_arbiter #(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int MW = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_ifu_cmd_valid,
  output logic          o_ifu_cmd_ready,
  input  logic          i_ifu_cmd_read,
  input  logic [AW-1:0] i_ifu_cmd_addr,
  input  logic [MW-1:0] i_ifu_cmd_wmask,
  input  logic [DW-1:0] i_ifu_cmd_wdata,
  output logic          o_ifu_rsp_valid,
  input  logic          i_ifu_rsp_ready,
  output logic [DW-1:0] o_ifu_rsp_rdata,
  input  logic          i_lsu_cmd_valid,
  output logic          o_lsu_cmd_ready,
  input  logic          i_lsu_cmd_read,
  input  logic [AW-1:0] i_lsu_cmd_addr,
  input  logic [MW-1:0] i_lsu_cmd_wmask,
  input  logic [DW-1:0] i_lsu_cmd_wdata,
  output logic          o_lsu_rsp_valid,
  input  logic          i_lsu_rsp_ready,
  output logic [DW-1:0] o_lsu_rsp_rdata,
  output logic          o_ram_cs,
  output logic          o_ram_we,
  output logic [AW-1:0] o_ram_addr,
  output logic [MW-1:0] o_ram_wem,
  output logic [DW-1:0] o_ram_din,
  input  logic [DW-1:0] i_ram_dout
);
  logic          r_rsp_pend, r_rsp_own, r_rsp_rd, r_first, r_last_gnt;
  logic [DW-1:0] r_hold_q;
  logic          w_rsp_fire, w_accept, w_sel_lsu, w_fire, w_read;
  logic [DW-1:0] w_rdata;
  always_comb begin
    w_rsp_fire      = r_rsp_pend & (r_rsp_own ? i_lsu_rsp_ready : i_ifu_rsp_ready);
    w_accept        = !r_rsp_pend | w_rsp_fire;
    // on conflict the requester that did not win last time goes next
    w_sel_lsu       = i_lsu_cmd_valid & (!i_ifu_cmd_valid | !r_last_gnt);
    w_fire          = w_accept & (i_ifu_cmd_valid | i_lsu_cmd_valid);
    w_read          = w_sel_lsu ? i_lsu_cmd_read : i_ifu_cmd_read;
    o_ifu_cmd_ready = w_accept & i_ifu_cmd_valid & !w_sel_lsu;
    o_lsu_cmd_ready = w_accept & w_sel_lsu;
    o_ram_cs        = w_fire;
    o_ram_we        = w_fire & !w_read;
    o_ram_addr      = !w_fire ? '0 : w_sel_lsu ? i_lsu_cmd_addr : i_ifu_cmd_addr;
    o_ram_wem       = !(w_fire & !w_read) ? '0 : w_sel_lsu ? i_lsu_cmd_wmask : i_ifu_cmd_wmask;
    o_ram_din       = !w_fire ? '0 : w_sel_lsu ? i_lsu_cmd_wdata : i_ifu_cmd_wdata;
    // RAM output is only valid for one cycle, so later response cycles use the held copy
    w_rdata         = !r_rsp_rd ? '0 : r_first ? i_ram_dout : r_hold_q;
    o_ifu_rsp_valid = r_rsp_pend & !r_rsp_own;
    o_lsu_rsp_valid = r_rsp_pend & r_rsp_own;
    o_ifu_rsp_rdata = o_ifu_rsp_valid ? w_rdata : '0;
    o_lsu_rsp_rdata = o_lsu_rsp_valid ? w_rdata : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_pend <= 1'b0;
      r_rsp_own  <= 1'b0;
      r_rsp_rd   <= 1'b0;
      r_first    <= 1'b0;
      r_hold_q   <= '0;
      r_last_gnt <= 1'b1;
    end else begin
      if (r_first) r_hold_q <= i_ram_dout;
      r_first <= w_fire;
      if (w_fire) begin
        r_rsp_pend <= 1'b1;
        r_rsp_own  <= w_sel_lsu;
        r_rsp_rd   <= w_read;
        r_last_gnt <= w_sel_lsu;
      end else if (w_rsp_fire) begin
        r_rsp_pend <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_itcm_arbiter.sv
// tb_itcm_arbiter: directed checks of arbitration, latency, stall hold, masked writes and async reset
module tb_itcm_arbiter;
  localparam int AW = 8, DW = 32, MW = 4;
  logic clk = 0, rst = 1;
  logic          ifu_cmd_valid = 0, ifu_cmd_ready, ifu_cmd_read = 1;
  logic [AW-1:0] ifu_cmd_addr = 0;
  logic [MW-1:0] ifu_cmd_wmask = 0;
  logic [DW-1:0] ifu_cmd_wdata = 0;
  logic          ifu_rsp_valid, ifu_rsp_ready = 1;
  logic [DW-1:0] ifu_rsp_rdata;
  logic          lsu_cmd_valid = 0, lsu_cmd_ready, lsu_cmd_read = 1;
  logic [AW-1:0] lsu_cmd_addr = 0;
  logic [MW-1:0] lsu_cmd_wmask = 0;
  logic [DW-1:0] lsu_cmd_wdata = 0;
  logic          lsu_rsp_valid, lsu_rsp_ready = 1;
  logic [DW-1:0] lsu_rsp_rdata;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_addr;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] ram_din, ram_dout;
  logic          ld_we = 0;
  logic [AW-1:0] ld_a = 0;
  logic [DW-1:0] ld_d = 0;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  itcm_arbiter #(.AW(AW), .DW(DW), .MW(MW)) dut (
    .clk(clk), .rst(rst),
    .i_ifu_cmd_valid(ifu_cmd_valid), .o_ifu_cmd_ready(ifu_cmd_ready), .i_ifu_cmd_read(ifu_cmd_read),
    .i_ifu_cmd_addr(ifu_cmd_addr), .i_ifu_cmd_wmask(ifu_cmd_wmask), .i_ifu_cmd_wdata(ifu_cmd_wdata),
    .o_ifu_rsp_valid(ifu_rsp_valid), .i_ifu_rsp_ready(ifu_rsp_ready), .o_ifu_rsp_rdata(ifu_rsp_rdata),
    .i_lsu_cmd_valid(lsu_cmd_valid), .o_lsu_cmd_ready(lsu_cmd_ready), .i_lsu_cmd_read(lsu_cmd_read),
    .i_lsu_cmd_addr(lsu_cmd_addr), .i_lsu_cmd_wmask(lsu_cmd_wmask), .i_lsu_cmd_wdata(lsu_cmd_wdata),
    .o_lsu_rsp_valid(lsu_rsp_valid), .i_lsu_rsp_ready(lsu_rsp_ready), .o_lsu_rsp_rdata(lsu_rsp_rdata),
    .o_ram_cs(ram_cs), .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_wem(ram_wem),
    .o_ram_din(ram_din), .i_ram_dout(ram_dout)
  );

  // RAM model: masked byte writes, read data valid only the cycle after a read
  always @(posedge clk) begin
    if (ld_we) mem[ld_a] <= ld_d;
    if (ram_cs && ram_we)
      for (int b = 0; b < MW; b++) if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    ram_dout <= (ram_cs && !ram_we) ? mem[ram_addr] : 'x;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_we = 1; ld_a = a; ld_d = d;
    tick();
    ld_we = 0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ifu_rv"}, {31'd0, ifu_rsp_valid}, 0);
    chk({tag, "_lsu_rv"}, {31'd0, lsu_rsp_valid}, 0);
    chk({tag, "_ifu_rd"}, ifu_rsp_rdata, 0);
    chk({tag, "_lsu_rd"}, lsu_rsp_rdata, 0);
    chk({tag, "_cs"}, {31'd0, ram_cs}, 0);
    chk({tag, "_we"}, {31'd0, ram_we}, 0);
    chk({tag, "_ram"}, {ram_addr, ram_wem, 20'd0} | ram_din, 0);
  endtask

  initial begin
    #1;
    load(8'h10, 32'hDEADBEEF);
    load(8'h00, 32'hA0A0A0A0);
    load(8'h01, 32'hA1A1A1A1);
    load(8'h02, 32'hA2A2A2A2);
    load(8'h20, 32'h12345678);
    load(8'h30, 32'h11223344);
    chk_idle_outputs("reset");
    rst = 0;
    tick();
    // single IFU read
    ifu_cmd_valid = 1; ifu_cmd_read = 1; ifu_cmd_addr = 8'h10;
    #1;
    chk("rd_ready", {31'd0, ifu_cmd_ready}, 1);
    chk("rd_cs", {31'd0, ram_cs}, 1);
    chk("rd_we", {31'd0, ram_we}, 0);
    chk("rd_addr", {24'd0, ram_addr}, 32'h10);
    chk("rd_wem", {28'd0, ram_wem}, 0);
    tick();
    ifu_cmd_valid = 0;
    #1;
    chk("rd_rv", {31'd0, ifu_rsp_valid}, 1);
    chk("rd_data", ifu_rsp_rdata, 32'hDEADBEEF);
    chk("rd_lsu_rv", {31'd0, lsu_rsp_valid}, 0);
    chk("rd_cs_off", {31'd0, ram_cs}, 0);
    tick();
    chk("rd_done", {31'd0, ifu_rsp_valid}, 0);
    // back-to-back IFU reads
    for (int i = 0; i < 4; i++) begin
      ifu_cmd_valid = (i < 3); ifu_cmd_addr = AW'(i);
      #1;
      if (i < 3) chk($sformatf("b2b_ready%0d", i), {31'd0, ifu_cmd_ready}, 1);
      if (i > 0) begin
        chk($sformatf("b2b_rv%0d", i), {31'd0, ifu_rsp_valid}, 1);
        chk($sformatf("b2b_data%0d", i), ifu_rsp_rdata, {4{8'hA0 + 8'(i - 1)}});
      end
      tick();
    end
    // both requesters valid continuously from reset
    rst = 1;
    tick();
    rst = 0;
    ifu_cmd_valid = 1; ifu_cmd_addr = 8'h00;
    lsu_cmd_valid = 1; lsu_cmd_read = 1; lsu_cmd_addr = 8'h01;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin ifu_cmd_valid = 0; lsu_cmd_valid = 0; end
      #1;
      if (i < 4) begin
        chk($sformatf("rr_ifu_rdy%0d", i), {31'd0, ifu_cmd_ready}, {31'd0, i % 2 == 0});
        chk($sformatf("rr_lsu_rdy%0d", i), {31'd0, lsu_cmd_ready}, {31'd0, i % 2 == 1});
        chk($sformatf("rr_addr%0d", i), {24'd0, ram_addr}, i % 2);
      end
      if (i > 0) begin
        chk($sformatf("rr_ifu_rv%0d", i), {31'd0, ifu_rsp_valid}, {31'd0, i % 2 == 1});
        chk($sformatf("rr_lsu_rv%0d", i), {31'd0, lsu_rsp_valid}, {31'd0, i % 2 == 0});
        chk($sformatf("rr_data%0d", i), ifu_rsp_rdata | lsu_rsp_rdata, (i % 2) ? 32'hA0A0A0A0 : 32'hA1A1A1A1);
      end
      tick();
    end
    // stalled response holds data while RAM output is undefined
    ifu_cmd_valid = 1; ifu_cmd_addr = 8'h20; ifu_rsp_ready = 0;
    tick();
    lsu_cmd_valid = 1; lsu_cmd_addr = 8'h01;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("st_rv%0d", i), {31'd0, ifu_rsp_valid}, 1);
      chk($sformatf("st_data%0d", i), ifu_rsp_rdata, 32'h12345678);
      chk($sformatf("st_ifu_rdy%0d", i), {31'd0, ifu_cmd_ready}, 0);
      chk($sformatf("st_lsu_rdy%0d", i), {31'd0, lsu_cmd_ready}, 0);
      chk($sformatf("st_cs%0d", i), {31'd0, ram_cs}, 0);
      tick();
    end
    ifu_cmd_valid = 0; lsu_cmd_valid = 0; ifu_rsp_ready = 1;
    #1;
    chk("st_rv_final", {31'd0, ifu_rsp_valid}, 1);
    chk("st_data_final", ifu_rsp_rdata, 32'h12345678);
    tick();
    chk("st_done", {31'd0, ifu_rsp_valid}, 0);
    // LSU masked write then IFU read of the same word
    lsu_cmd_valid = 1; lsu_cmd_read = 0; lsu_cmd_addr = 8'h30;
    lsu_cmd_wdata = 32'hAABBCCDD; lsu_cmd_wmask = 4'b0011;
    #1;
    chk("wr_ready", {31'd0, lsu_cmd_ready}, 1);
    chk("wr_we", {31'd0, ram_we}, 1);
    chk("wr_wem", {28'd0, ram_wem}, 4'b0011);
    chk("wr_din", ram_din, 32'hAABBCCDD);
    tick();
    lsu_cmd_valid = 0;
    ifu_cmd_valid = 1; ifu_cmd_read = 1; ifu_cmd_addr = 8'h30;
    #1;
    chk("wr_lsu_rv", {31'd0, lsu_rsp_valid}, 1);
    chk("wr_lsu_rd", lsu_rsp_rdata, 0);
    chk("wr_ifu_rdy", {31'd0, ifu_cmd_ready}, 1);
    tick();
    ifu_cmd_valid = 0;
    #1;
    chk("wr_ifu_data", ifu_rsp_rdata, 32'h1122CCDD);
    tick();
    // asynchronous reset during a stalled response
    ifu_cmd_valid = 1; ifu_cmd_addr = 8'h10; ifu_rsp_ready = 0;
    tick();
    ifu_cmd_valid = 0;
    tick();
    chk("ar_stalled", {31'd0, ifu_rsp_valid}, 1);
    #2 rst = 1;
    #1;
    chk_idle_outputs("ar_async");
    tick();
    rst = 0; ifu_rsp_ready = 1;
    #1;
    chk("ar_no_cs", {31'd0, ram_cs}, 0);
    tick();
    chk("ar_no_rsp", {31'd0, ifu_rsp_valid}, 0);
    ifu_cmd_valid = 1;
    #1;
    chk("ar_fresh_rdy", {31'd0, ifu_cmd_ready}, 1);
    tick();
    ifu_cmd_valid = 0;
    #1;
    chk("ar_fresh_rv", {31'd0, ifu_rsp_valid}, 1);
    chk("ar_fresh_data", ifu_rsp_rdata, 32'hDEADBEEF);
    tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
